// File: rtl/pipe_logic_unit_if.sv
// Valid/ready bus for the pipelined logic unit: input operands/op on one side,
// result on the other. The master side drives transactions and consumes results.
interface pipe_logic_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_z;

    modport master (
        output in_valid, in_op, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_z
    );

    modport slave (
        input  in_valid, in_op, in_x, in_y, out_ready,
        output in_ready, out_valid, out_z
    );
endinterface

// File: rtl/pipe_logic_unit.sv
// DEPTH-stage pipelined bitwise logic unit (AND/OR/XOR/ANDN) with valid/ready
// handshakes, bubble collapse, synchronous flush and a registered occupancy count.
module pipe_logic_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    pipe_logic_unit_if.slave   bus,
    output logic [CNT_W-1:0]   occupancy
);

    logic [DEPTH-1:0] stage_valid;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] op_result;
    logic             in_ready;
    logic             in_fire;
    logic             out_fire;

    always_comb begin
        op_result = '0;
        unique case (bus.in_op)
            2'b00:   op_result = bus.in_x & bus.in_y;
            2'b01:   op_result = bus.in_x | bus.in_y;
            2'b10:   op_result = bus.in_x ^ bus.in_y;
            default: op_result = bus.in_x & ~bus.in_y;
        endcase
    end

    // A stage may load when the stage after it moves or when it is empty, so
    // bubbles collapse and ready ripples combinationally back from out_ready.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = bus.out_ready | ~stage_valid[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) begin
            adv[k] = adv[k+1] | ~stage_valid[k];
        end
    end

    assign in_ready      = adv[0] & ~flush & reset;
    assign in_fire       = bus.in_valid & in_ready;
    assign out_fire      = stage_valid[DEPTH-1] & bus.out_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = stage_valid[DEPTH-1];
    assign bus.out_z     = stage_data[DEPTH-1];

    // Flush only clears valid bits; stale data behind an invalid stage is harmless.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stage_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                stage_data[k] <= '0;
            end
        end else if (flush) begin
            stage_valid <= '0;
        end else begin
            if (adv[0]) begin
                stage_valid[0] <= in_fire;
                stage_data[0]  <= op_result;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (adv[k]) begin
                    stage_valid[k] <= stage_valid[k-1];
                    stage_data[k]  <= stage_data[k-1];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else begin
            unique case ({in_fire, out_fire})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: doc/pipe_logic_unit.md
Name: pipe_logic_unit

Overview:
- Parametrised successor to the PD0 registered-AND exercises: a WIDTH-bit, DEPTH-stage pipelined bitwise logic unit.
- Each transaction selects its own operation: AND, OR, XOR or ANDN.
- Valid/ready handshake on both sides, with per-stage bubble collapse, a synchronous flush and an occupancy count.
- Sits in the pd0 core as the reference pipeline primitive that later PD stages (ALU/forwarding experiments) reuse.

Parameters:
- WIDTH, 32, operand/result width in bits (>=1).
- DEPTH, 2, number of register stages (>=1); zero-backpressure latency equals DEPTH.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset. Assert asynchronously; release synchronous to clock.
- flush  in  1  synchronous flush; drops every in-flight transaction.
- in_valid  in  1  input transaction present.
- in_ready  out  1  unit accepts input this cycle.
- in_op  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 ANDN (x & ~y).
- in_x  in  WIDTH  operand x.
- in_y  in  WIDTH  operand y.
- out_valid  out  1  result present in the last stage.
- out_ready  in  1  consumer accepts the result.
- out_z  out  WIDTH  result.
- occupancy  out  CNT_W  number of valid stages.

Behaviour:
- Reset (reset==0): all stage valid bits, stage data and occupancy clear to 0 immediately, without a clock.
  - Gives out_valid=0, out_z=0, occupancy=0.
  - in_ready is 0 while reset is asserted.
  - Reset mid-operation discards all in-flight data silently.
- Compute:
  - The logic op is evaluated combinationally on in_x/in_y/in_op and captured into stage 0.
  - Stages 1..DEPTH-1 carry the result unchanged; out_z is the stage DEPTH-1 data.
  - No arithmetic, so there is no width growth.
- Stage advance rule, for stage k:
  - adv[DEPTH-1] = out_ready | ~v[DEPTH-1].
  - adv[k] = adv[k+1] | ~v[k].
  - When adv[k] holds, stage k loads from stage k-1 (or from the input for k=0), and its valid bit takes the upstream valid.
  - Otherwise stage k holds.
  - Bubbles collapse: an empty stage always accepts.
- Handshakes:
  - in_ready = adv[0] & ~flush & reset.
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - out_z and out_valid stay stable while out_valid & ~out_ready.
- Latency:
  - With out_ready held 1, an input accepted at edge N is presented at out_valid/out_z after edge N+DEPTH-1, so it is visible DEPTH cycles after the input cycle.
  - Throughput is 1 per cycle.
- Full: when all DEPTH stages are valid and out_ready=0, in_ready=0 and nothing moves.
  - Full with out_ready=1: in_ready=1 in the same cycle (pass-through of ready is combinational). This gives full throughput with no bubble.
- Flush:
  - On the next edge, all valid bits clear and occupancy becomes 0.
  - in_valid during flush is dropped (in_ready=0).
  - out_valid remains visible in the flush cycle. An output transfer in that cycle still counts as consumed; the bench must not score it as an error.
  - Data registers may keep stale values; only valid bits are architecturally meaningful after flush.
- Occupancy:
  - Equals popcount of the valid bits, registered.
  - Updates as +1 on input transfer only, -1 on output transfer only, and unchanged on both or neither; flush → 0.
  - Never exceeds DEPTH and never underflows.
- X-safety: out_valid never X after reset release; out_z is X-free whenever out_valid=1, given X-free inputs.

Test Plan:
- Reset release, DEPTH=2, WIDTH=32, out_ready=1, in_x=0xF0F0F0F0, in_y=0xFF00FF00, op AND on cycle 0 → out_valid=1 with out_z=0xF000F000 exactly 2 cycles later; occupancy reads 1 between.
- Stream ops AND/OR/XOR/ANDN back-to-back with x=0xC, y=0xA (WIDTH=4), out_ready=1 → outputs 0x8, 0xE, 0x6, 0x4 in order, one per cycle, in_ready constantly 1.
- Backpressure, DEPTH=3: out_ready=0, send 5 transactions → exactly 3 accepted, occupancy=3, in_ready=0. Then raise out_ready for 1 cycle → one output, in_ready=1 same cycle, occupancy stays 3 if in_valid=1.
- Bubble collapse: inject one transaction, idle 1 cycle, inject a second, hold out_ready=0 → both reach adjacent stages, occupancy=2, first result held stable on out_z.
- Flush with pipe full and in_valid=1 → next cycle out_valid=0, occupancy=0, flush-cycle input not delivered later.
- Async reset asserted mid-stream, between clock edges → out_valid/occupancy go 0 before the next rising edge. After release, the first new transaction emerges with correct value and DEPTH-cycle latency.
